// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Fetch sequencer between the core's PC/redirect logic and the I-cache.
// Owns the fetch PC, issues sequential word fetches, tracks in-flight
// requests, drops responses that belong to the pre-redirect stream, and
// buffers returned instructions (with their PCs) for decode.
//
// Parameters
//   RESET_PC         fetch PC after reset (word aligned)
//   MAX_OUTSTANDING  accepted-but-unanswered I-cache requests (1..4)
//   IBUF_DEPTH       instruction buffer entries (>= MAX_OUTSTANDING)
//
// Ports
//   clk_i, rst_ni                    clock, async active-low reset
//   redir_i, redir_pc_i              redirect pulse and target
//   ic_req_valid_o/ready_i/addr_o    I-cache request handshake
//   ic_rsp_valid_i, ic_rsp_data_i    in-order I-cache responses
//   inst_valid_o/ready_i             decode handshake on the buffer head
//   inst_o, inst_pc_o                head instruction and its PC (0 if empty)
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          IBUF_DEPTH      = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        redir_i,
    input  logic [31:0] redir_pc_i,
    output logic        ic_req_valid_o,
    input  logic        ic_req_ready_i,
    output logic [31:0] ic_req_addr_o,
    input  logic        ic_rsp_valid_i,
    input  logic [31:0] ic_rsp_data_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW = $clog2(IBUF_DEPTH + 1);
    localparam int PW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ibuf_entry_t;

    state_e         state_q,  state_d;
    logic [31:0]    pc_q,     pc_d;
    logic [31:0]    rsp_pc_q, rsp_pc_d;   // PC of the next response to keep
    logic [CW-1:0]  outs_q,   outs_d;     // accepted, not yet answered
    logic [CW-1:0]  disc_q,   disc_d;     // stale responses still to drop
    logic [PW-1:0]  head_q,   head_d;
    logic [PW-1:0]  tail_q,   tail_d;
    logic [BW-1:0]  cnt_q,    cnt_d;
    ibuf_entry_t    mem_q [IBUF_DEPTH];

    logic        buf_empty;
    logic        req_fire;
    logic        rsp_drop;
    logic        push;
    logic        pop;
    logic [31:0] redir_tgt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(IBUF_DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    assign buf_empty = (cnt_q == '0);
    assign redir_tgt = redir_pc_i & 32'hFFFF_FFFC;

    // Space is reserved for every in-flight request, so a kept response can
    // never find the buffer full.
    assign ic_req_valid_o = (state_q == RUN) && !redir_i
                         && (int'(outs_q) + int'(cnt_q) < IBUF_DEPTH)
                         && (int'(outs_q) < MAX_OUTSTANDING);
    assign ic_req_addr_o  = pc_q;

    assign req_fire = ic_req_valid_o && ic_req_ready_i;
    assign rsp_drop = ic_rsp_valid_i && (disc_q != '0);
    // A redirect flushes the buffer, so same-cycle push/pop are suppressed.
    assign push     = ic_rsp_valid_i && (disc_q == '0) && !redir_i;
    assign pop      = inst_valid_o && inst_ready_i && !redir_i;

    assign inst_valid_o = !buf_empty;
    assign inst_o       = buf_empty ? '0 : mem_q[head_q].inst;
    assign inst_pc_o    = buf_empty ? '0 : mem_q[head_q].pc;

    always_comb begin
        // NOTE: every signal gets a default before any branch; otherwise a
        // path that skips an assignment infers a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        outs_d   = outs_q;
        disc_d   = disc_q;
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;

        if (redir_i) begin
            // No request is issued in a redirect cycle, and any response
            // arriving now belongs to the old stream.
            pc_d     = redir_tgt;
            rsp_pc_d = redir_tgt;
            head_d   = '0;
            tail_d   = '0;
            cnt_d    = '0;
            outs_d   = outs_q - CW'(ic_rsp_valid_i);
            disc_d   = outs_d;
            state_d  = (disc_d != '0) ? DRAIN : RUN;
        end else begin
            if (req_fire) pc_d = pc_q + 32'd4;
            outs_d = outs_q + CW'(req_fire) - CW'(ic_rsp_valid_i);
            if (rsp_drop) disc_d = disc_q - CW'(1);
            if (push) begin
                tail_d   = ptr_inc(tail_q);
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (pop) head_d = ptr_inc(head_q);
            cnt_d = cnt_q + BW'(push) - BW'(pop);

            case (state_q)
                BOOT:    state_d = RUN;
                DRAIN:   if (disc_d == '0) state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_ni) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outs_q   <= '0;
            disc_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            outs_q   <= outs_d;
            disc_q   <= disc_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: the buffer storage has no reset; cnt_q gates every read, so the
    // contents of empty slots never reach the outputs.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[tail_q] <= '{pc: rsp_pc_q, inst: ic_rsp_data_i};
    end

endmodule
